// File: rtl/divider_if.sv
// Load/response bus between the execute stage and the iterative divider.
interface divider_if #(
  parameter int WIDTH = 32
);
  logic             divider_load;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divider_resp;

  modport master (
    output divider_load,
    output dividend,
    output divisor,
    output is_signed,
    input  quotient,
    input  remainder,
    input  divider_resp
  );

  modport slave (
    input  divider_load,
    input  dividend,
    input  divisor,
    input  is_signed,
    output quotient,
    output remainder,
    output divider_resp
  );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider with RV32M DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle; a final divide cycle applies the sign fix-up,
// so a normal operation responds 33 cycles after the load edge, while
// divide-by-zero and signed overflow respond right after the load edge.
module divider #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  divider_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH:0]   rem_part_q, rem_part_d;
  logic [WIDTH-1:0] dvd_shift_q, dvd_shift_d;
  logic [WIDTH-1:0] div_mag_q, div_mag_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             trial_ge;
  logic             unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit is zero
  // and the shifted trial value fits in WIDTH+1 bits.
  assign trial          = {rem_part_q[WIDTH-1:0], dvd_shift_q[WIDTH-1]};
  assign diff           = trial - {1'b0, div_mag_q};
  assign trial_ge       = trial >= {1'b0, div_mag_q};
  assign unused_rem_msb = rem_part_q[WIDTH];

  assign bus.quotient     = quotient_q;
  assign bus.remainder    = remainder_q;
  assign bus.divider_resp = (state_q == DONE);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_part_q  <= '0;
      dvd_shift_q <= '0;
      div_mag_q   <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_part_q  <= rem_part_d;
      dvd_shift_q <= dvd_shift_d;
      div_mag_q   <= div_mag_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // Next-state: operand capture, shift/subtract iterations and sign fix-up.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_part_d  = rem_part_q;
    dvd_shift_d = dvd_shift_q;
    div_mag_d   = div_mag_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE: begin
        if (bus.divider_load) begin
          if (bus.divisor == '0) begin
            quotient_d  = '1;
            remainder_d = bus.dividend;
            state_d     = DONE;
          end else if (bus.is_signed && bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}
                       && bus.divisor == '1) begin
            quotient_d  = {1'b1, {(WIDTH-1){1'b0}}};
            remainder_d = '0;
            state_d     = DONE;
          end else begin
            dvd_shift_d = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
            div_mag_d   = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
            q_neg_d     = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg_d     = bus.is_signed & bus.dividend[WIDTH-1];
            rem_part_d  = '0;
            count_d     = '0;
            state_d     = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (count_q == CNT_W'(WIDTH)) begin
          quotient_d  = q_neg_q ? -dvd_shift_q : dvd_shift_q;
          remainder_d = r_neg_q ? -rem_part_q[WIDTH-1:0] : rem_part_q[WIDTH-1:0];
          state_d     = DONE;
        end else begin
          rem_part_d  = trial_ge ? diff : trial;
          dvd_shift_d = {dvd_shift_q[WIDTH-2:0], trial_ge};
          count_d     = count_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the iterative divider.
module tb_divider;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cycle_cnt;

  divider_if #(.WIDTH(32)) bus ();

  divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to measure response latency.
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Drives one load for a single edge; returns the edge index of acceptance
  // and leaves the caller on the falling edge right after that load edge.
  task automatic apply_load(input logic [31:0] dvd, input logic [31:0] dvs,
                            input logic sgn, output int e0);
    @(negedge clk);
    bus.divider_load = 1'b1;
    bus.dividend     = dvd;
    bus.divisor      = dvs;
    bus.is_signed    = sgn;
    @(negedge clk);
    e0 = cycle_cnt;
    bus.divider_load = 1'b0;
    bus.dividend     = 32'h0;
    bus.divisor      = 32'h0;
    bus.is_signed    = 1'b0;
  endtask

  // Waits (bounded) for divider_resp; returns edges since load, or -1 on timeout.
  task automatic wait_resp(input int e0, output int offset);
    int guard;
    guard = 0;
    while (bus.divider_resp !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    offset = (bus.divider_resp === 1'b1) ? (cycle_cnt - e0) : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.quotient !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_quotient: got %h expected %h", bus.quotient, 32'h0);
    end
    checks++;
    if (bus.remainder !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_remainder: got %h expected %h", bus.remainder, 32'h0);
    end
    checks++;
    if (bus.divider_resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_resp: got %b expected 0", bus.divider_resp);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int e0, off;
    apply_load(32'd100, 32'd7, 1'b0, e0);
    wait_resp(e0, off);
    checks++;
    if (off !== 33) begin
      errors++;
      $display("[TB] FAIL unsigned_latency: got %0d expected 33", off);
    end
    checks++;
    if (bus.quotient !== 32'd14) begin
      errors++;
      $display("[TB] FAIL unsigned_quotient: got %h expected %h", bus.quotient, 32'd14);
    end
    checks++;
    if (bus.remainder !== 32'd2) begin
      errors++;
      $display("[TB] FAIL unsigned_remainder: got %h expected %h", bus.remainder, 32'd2);
    end
    @(negedge clk);
    checks++;
    if (bus.divider_resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unsigned_resp_pulse: got %b expected 0", bus.divider_resp);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.quotient !== 32'd14) begin
      errors++;
      $display("[TB] FAIL unsigned_hold_quotient: got %h expected %h", bus.quotient, 32'd14);
    end
    checks++;
    if (bus.remainder !== 32'd2) begin
      errors++;
      $display("[TB] FAIL unsigned_hold_remainder: got %h expected %h", bus.remainder, 32'd2);
    end
    // Zero dividend takes the full-latency path.
    apply_load(32'd0, 32'd5, 1'b0, e0);
    wait_resp(e0, off);
    checks++;
    if (off !== 33) begin
      errors++;
      $display("[TB] FAIL zero_dividend_latency: got %0d expected 33", off);
    end
    checks++;
    if (bus.quotient !== 32'd0) begin
      errors++;
      $display("[TB] FAIL zero_dividend_quotient: got %h expected %h", bus.quotient, 32'd0);
    end
    checks++;
    if (bus.remainder !== 32'd0) begin
      errors++;
      $display("[TB] FAIL zero_dividend_remainder: got %h expected %h", bus.remainder, 32'd0);
    end
  endtask

  task automatic test_signed();
    int e0, off;
    logic [31:0] dvd_v [2];
    logic [31:0] dvs_v [2];
    logic [31:0] q_v   [2];
    logic [31:0] r_v   [2];
    dvd_v[0] = 32'hFFFFFFF9; dvs_v[0] = 32'd2;        q_v[0] = 32'hFFFFFFFD; r_v[0] = 32'hFFFFFFFF;
    dvd_v[1] = 32'd7;        dvs_v[1] = 32'hFFFFFFFE; q_v[1] = 32'hFFFFFFFD; r_v[1] = 32'd1;
    for (int i = 0; i < 2; i++) begin
      apply_load(dvd_v[i], dvs_v[i], 1'b1, e0);
      wait_resp(e0, off);
      checks++;
      if (off !== 33) begin
        errors++;
        $display("[TB] FAIL signed_latency[%0d]: got %0d expected 33", i, off);
      end
      checks++;
      if (bus.quotient !== q_v[i]) begin
        errors++;
        $display("[TB] FAIL signed_quotient[%0d]: got %h expected %h", i, bus.quotient, q_v[i]);
      end
      checks++;
      if (bus.remainder !== r_v[i]) begin
        errors++;
        $display("[TB] FAIL signed_remainder[%0d]: got %h expected %h", i, bus.remainder, r_v[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int e0, off;
    for (int s = 0; s < 2; s++) begin
      apply_load(32'h12345678, 32'h0, s[0], e0);
      wait_resp(e0, off);
      checks++;
      if (off !== 0) begin
        errors++;
        $display("[TB] FAIL divzero_latency[s=%0d]: got %0d expected 0 edges after load", s, off);
      end
      checks++;
      if (bus.quotient !== 32'hFFFFFFFF) begin
        errors++;
        $display("[TB] FAIL divzero_quotient[s=%0d]: got %h expected %h", s, bus.quotient, 32'hFFFFFFFF);
      end
      checks++;
      if (bus.remainder !== 32'h12345678) begin
        errors++;
        $display("[TB] FAIL divzero_remainder[s=%0d]: got %h expected %h", s, bus.remainder, 32'h12345678);
      end
    end
  endtask

  task automatic test_overflow();
    int e0, off;
    apply_load(32'h80000000, 32'hFFFFFFFF, 1'b1, e0);
    wait_resp(e0, off);
    checks++;
    if (off !== 0) begin
      errors++;
      $display("[TB] FAIL overflow_latency: got %0d expected 0 edges after load", off);
    end
    checks++;
    if (bus.quotient !== 32'h80000000) begin
      errors++;
      $display("[TB] FAIL overflow_quotient: got %h expected %h", bus.quotient, 32'h80000000);
    end
    checks++;
    if (bus.remainder !== 32'h0) begin
      errors++;
      $display("[TB] FAIL overflow_remainder: got %h expected %h", bus.remainder, 32'h0);
    end
    apply_load(32'h80000000, 32'hFFFFFFFF, 1'b0, e0);
    wait_resp(e0, off);
    checks++;
    if (off !== 33) begin
      errors++;
      $display("[TB] FAIL large_unsigned_latency: got %0d expected 33", off);
    end
    checks++;
    if (bus.quotient !== 32'h0) begin
      errors++;
      $display("[TB] FAIL large_unsigned_quotient: got %h expected %h", bus.quotient, 32'h0);
    end
    checks++;
    if (bus.remainder !== 32'h80000000) begin
      errors++;
      $display("[TB] FAIL large_unsigned_remainder: got %h expected %h", bus.remainder, 32'h80000000);
    end
  endtask

  task automatic test_back_to_back();
    int e0, off;
    apply_load(32'd1000, 32'd10, 1'b0, e0);
    // A load pulse while busy must be ignored.
    repeat (4) @(negedge clk);
    bus.divider_load = 1'b1;
    bus.dividend     = 32'd9;
    bus.divisor      = 32'd3;
    @(negedge clk);
    bus.divider_load = 1'b0;
    bus.dividend     = 32'h0;
    bus.divisor      = 32'h0;
    wait_resp(e0, off);
    checks++;
    if (off !== 33) begin
      errors++;
      $display("[TB] FAIL busy_latency: got %0d expected 33", off);
    end
    checks++;
    if (bus.quotient !== 32'd100) begin
      errors++;
      $display("[TB] FAIL busy_quotient: got %h expected %h", bus.quotient, 32'd100);
    end
    checks++;
    if (bus.remainder !== 32'd0) begin
      errors++;
      $display("[TB] FAIL busy_remainder: got %h expected %h", bus.remainder, 32'd0);
    end
    // Load in the first idle cycle after the response.
    apply_load(32'd9, 32'd3, 1'b0, e0);
    wait_resp(e0, off);
    checks++;
    if (off !== 33) begin
      errors++;
      $display("[TB] FAIL b2b_latency: got %0d expected 33", off);
    end
    checks++;
    if (bus.quotient !== 32'd3) begin
      errors++;
      $display("[TB] FAIL b2b_quotient: got %h expected %h", bus.quotient, 32'd3);
    end
    checks++;
    if (bus.remainder !== 32'd0) begin
      errors++;
      $display("[TB] FAIL b2b_remainder: got %h expected %h", bus.remainder, 32'd0);
    end
  endtask

  task automatic test_reset_mid_op();
    int e0, off, resp_seen;
    apply_load(32'hFFFFFFFF, 32'd1, 1'b0, e0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.quotient !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_quotient: got %h expected %h", bus.quotient, 32'h0);
    end
    checks++;
    if (bus.remainder !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_remainder: got %h expected %h", bus.remainder, 32'h0);
    end
    rst = 1'b0;
    resp_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.divider_resp !== 1'b0) resp_seen++;
      @(negedge clk);
    end
    checks++;
    if (resp_seen !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_no_resp: got %0d resp cycles expected 0", resp_seen);
    end
    apply_load(32'd50, 32'd5, 1'b0, e0);
    wait_resp(e0, off);
    checks++;
    if (off !== 33) begin
      errors++;
      $display("[TB] FAIL after_reset_latency: got %0d expected 33", off);
    end
    checks++;
    if (bus.quotient !== 32'd10) begin
      errors++;
      $display("[TB] FAIL after_reset_quotient: got %h expected %h", bus.quotient, 32'd10);
    end
    checks++;
    if (bus.remainder !== 32'd0) begin
      errors++;
      $display("[TB] FAIL after_reset_remainder: got %h expected %h", bus.remainder, 32'd0);
    end
  endtask

  // Scenario sequence.
  initial begin
    checks           = 0;
    errors           = 0;
    cycle_cnt        = 0;
    rst              = 1'b1;
    bus.divider_load = 1'b0;
    bus.dividend     = 32'h0;
    bus.divisor      = 32'h0;
    bus.is_signed    = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
